sort_engine: RTL

- Parametrised, cycle-stepped bubble-sort engine for the OLED sorting visualiser.
- Holds N values of W bits. Loads them from the RNG over a valid/ready stream.
- Sorts with one compare/swap per pacing tick, so the bar renderer can animate every step.
- Exposes a random-access read port, plus the current compare index and swap flag, so the renderer can highlight activity.

---
 rtl/sort_pkg.sv | 21 ++
 rtl/sort_pacer.sv | 28 ++
 rtl/sort_engine.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the cycle-stepped bubble-sort engine.
package sort_pkg;

  localparam int unsigned DEF_N        = 10;
  localparam int unsigned DEF_W        = 7;
  localparam int unsigned DEF_STEP_DIV = 1;
  localparam int unsigned STAT_W       = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_SORT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index width for an N-entry array, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_pacer.sv
// Step pacer: tick every STEP_DIV enabled cycles, first tick STEP_DIV cycles after clear.
module sort_pacer #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = (STEP_DIV < 2) ? 1 : $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  // With STEP_DIV == 1 the counter is stuck at zero and tick follows en.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick_c = en && (cnt == LAST);

endmodule

// File: rtl/sort_engine.sv
// Bubble-sort engine for the sorting visualiser: one compare/swap per pacer tick.
// Define SORT_STATS_EN to add saturating cmp_count/swap_count outputs.
module sort_engine
  import sort_pkg::*;
#(
  parameter  int unsigned N        = DEF_N,
  parameter  int unsigned W        = DEF_W,
  parameter  int unsigned STEP_DIV = DEF_STEP_DIV,
  localparam int unsigned IW       = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_valid,
  input  logic [W-1:0]  load_data,
  output logic          load_ready,
  input  logic          start,
  input  logic          descending,
  output logic          busy,
  output logic          done,
  output logic          sorted,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  output logic [IW-1:0] cmp_idx,
  output logic          swap_flag
`ifdef SORT_STATS_EN
  ,
  output logic [STAT_W-1:0] cmp_count,
  output logic [STAT_W-1:0] swap_count
`endif
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_LOAD = CW'(N - 1);
  localparam logic [IW-1:0] LAST_J    = IW'(N - 2);

  state_e state, state_next;

  logic [W-1:0]  elem [N];
  logic [CW-1:0] count;
  logic [IW-1:0] pass;
  logic [IW-1:0] j;
  logic          dir;
  logic          swapped;
  logic          tick_c;

  logic          load_en_c;
  logic          start_en_c;
  logic          cmp_c;
  logic          do_swap_c;
  logic          pass_end_c;
  logic          finish_c;
  logic [W-1:0]  lo_c;
  logic [W-1:0]  hi_c;

  sort_pacer #(.STEP_DIV(STEP_DIV)) u_pacer (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_en_c),
    .en     (state == ST_SORT),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_next;
  end

  // Next state plus the per-cycle strobes that drive the datapath.
  always_comb begin
    state_next = state;
    load_en_c  = 1'b0;
    start_en_c = 1'b0;
    cmp_c      = 1'b0;
    do_swap_c  = 1'b0;
    pass_end_c = 1'b0;
    finish_c   = 1'b0;
    lo_c       = elem[j];
    hi_c       = elem[j + IW'(1)];
    unique case (state)
      ST_LOAD: begin
        load_en_c = load_valid;
        if (load_valid && (count == LAST_LOAD)) state_next = ST_READY;
      end
      ST_READY, ST_DONE: begin
        start_en_c = start;
        if (start) state_next = ST_SORT;
      end
      ST_SORT: begin
        if (tick_c) begin
          cmp_c      = 1'b1;
          do_swap_c  = dir ? (lo_c < hi_c) : (lo_c > hi_c);
          pass_end_c = (j == (LAST_J - pass));
          // Early exit on a swap-free pass; the last possible pass always ends.
          if (pass_end_c && (!(swapped || do_swap_c) || (pass == LAST_J))) begin
            finish_c   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      default: state_next = ST_LOAD;
    endcase
    if (clear) begin
      state_next = ST_LOAD;
      load_en_c  = 1'b0;
      start_en_c = 1'b0;
      cmp_c      = 1'b0;
      do_swap_c  = 1'b0;
      pass_end_c = 1'b0;
      finish_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) elem[i] <= '0;
      count      <= '0;
      pass       <= '0;
      j          <= '0;
      dir        <= 1'b0;
      swapped    <= 1'b0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      sorted     <= 1'b0;
      swap_flag  <= 1'b0;
    end else begin
      load_ready <= (state_next == ST_LOAD);
      busy       <= (state_next == ST_SORT);
      sorted     <= (state_next == ST_DONE);
      done       <= finish_c;
      swap_flag  <= do_swap_c;

      if (clear) begin
        count   <= '0;
        pass    <= '0;
        j       <= '0;
        swapped <= 1'b0;
      end

      if (load_en_c) begin
        elem[count] <= load_data;
        count       <= count + CW'(1);
      end

      if (start_en_c) begin
        dir     <= descending;
        pass    <= '0;
        j       <= '0;
        swapped <= 1'b0;
      end

      if (cmp_c) begin
        if (do_swap_c) begin
          elem[j]          <= hi_c;
          elem[j + IW'(1)] <= lo_c;
          swapped          <= 1'b1;
        end
        if (!pass_end_c) begin
          j <= j + IW'(1);
        end else if (!finish_c) begin
          pass    <= pass + IW'(1);
          j       <= '0;
          swapped <= 1'b0;
        end
      end
    end
  end

  assign cmp_idx = j;
  assign rd_data = (32'(rd_idx) < N) ? elem[rd_idx] : '0;

`ifdef SORT_STATS_EN
  // Saturating activity counters, zeroed whenever a new sort begins.
  always_ff @(posedge clk) begin
    if (rst || clear || start_en_c) begin
      cmp_count  <= '0;
      swap_count <= '0;
    end else begin
      if (cmp_c && (cmp_count != '1))
        cmp_count <= cmp_count + STAT_W'(1);
      if (do_swap_c && (swap_count != '1))
        swap_count <= swap_count + STAT_W'(1);
    end
  end
`endif

endmodule
